// File: rtl/leaf_switch.sv
// Five-input, five-output leaf switch: four NI leaves plus one group uplink, with per-input FIFOs and round-robin output arbiters.
// A flit accepted at edge k appears valid after edge k+1. Inputs stall when their FIFO is full; the uplink output holds while up_out_ready is low.

module leaf_switch_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module leaf_switch #(
    parameter int GROUP_ID   = 8,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DATA_W-1:0] loc_in_data,
    input  logic [3:0]          loc_in_valid,
    output logic [3:0]          loc_in_ready,
    output logic [4*DATA_W-1:0] loc_out_data,
    output logic [3:0]          loc_out_valid,
    input  logic [DATA_W-1:0]   up_in_data,
    input  logic                up_in_valid,
    output logic                up_in_ready,
    output logic [DATA_W-1:0]   up_out_data,
    output logic                up_out_valid,
    input  logic                up_out_ready,
    output logic [7:0]          drop_count
);
    localparam int NP = 5;
    localparam int UP = 4;
    localparam logic [3:0] GID = 4'(GROUP_ID);

    logic [NP-1:0][DATA_W-1:0] in_dat;
    logic [NP-1:0][DATA_W-1:0] head;
    logic [NP-1:0][DATA_W-1:0] gdat;
    logic [NP-1:0]             in_vld;
    logic [NP-1:0]             push;
    logic [NP-1:0]             pop;
    logic [NP-1:0]             full;
    logic [NP-1:0]             empty;
    logic [NP-1:0][2:0]        tgt;
    logic [NP-1:0][NP-1:0]     req;
    logic [NP-1:0][NP-1:0]     gnt;
    logic [NP-1:0]             gany;
    logic [NP-1:0][2:0]        gidx;
    logic [NP-1:0][2:0]        last_grant;
    logic                      up_load_ok;
    logic                      up_match;

    assign in_dat     = {up_in_data, loc_in_data};
    assign in_vld     = {up_in_valid, loc_in_valid};
    assign up_match   = (up_in_data[DATA_W-1 -: 4] == GID);
    // Misrouted uplink flits are accepted but never written.
    assign push       = in_vld & ~full & {up_match, 4'hF};
    assign loc_in_ready = ~full[3:0];
    assign up_in_ready  = ~full[UP];
    assign up_load_ok   = !up_out_valid || up_out_ready;

    for (genvar i = 0; i < NP; i++) begin : g_port
        leaf_switch_fifo #(
            .W     (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[i]),
            .push_dat (in_dat[i]),
            .pop      (pop[i]),
            .head     (head[i]),
            .full     (full[i]),
            .empty    (empty[i])
        );

        assign tgt[i] = (head[i][DATA_W-1 -: 4] == GID) ? {1'b0, head[i][DATA_W-5 -: 2]} : 3'(UP);
    end

    always_comb begin
        int idx;
        idx  = 0;
        req  = '0;
        gnt  = '0;
        gany = '0;
        gidx = '0;
        gdat = '0;
        pop  = '0;
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                req[o][i] = !empty[i] && (tgt[i] == 3'(o)) && ((o != UP) || up_load_ok);
            end
        end
        // Search starts one past the last winner and wraps 4 -> 0.
        for (int o = 0; o < NP; o++) begin
            for (int k = 1; k <= NP; k++) begin
                idx = int'(last_grant[o]) + k;
                if (idx >= NP) begin
                    idx = idx - NP;
                end
                if (!gany[o] && req[o][idx]) begin
                    gany[o]     = 1'b1;
                    gnt[o][idx] = 1'b1;
                    gidx[o]     = 3'(idx);
                    gdat[o]     = head[idx];
                end
            end
            pop = pop | gnt[o];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant    <= {NP{3'(UP)}};
            loc_out_valid <= '0;
            loc_out_data  <= '0;
            up_out_valid  <= 1'b0;
            up_out_data   <= '0;
            drop_count    <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (gany[o]) begin
                    last_grant[o] <= gidx[o];
                end
            end
            for (int o = 0; o < 4; o++) begin
                loc_out_valid[o] <= gany[o];
                if (gany[o]) begin
                    loc_out_data[o*DATA_W +: DATA_W] <= gdat[o];
                end
            end
            if (up_load_ok) begin
                up_out_valid <= gany[UP];
                if (gany[UP]) begin
                    up_out_data <= gdat[UP];
                end
            end
            if (up_in_valid && up_in_ready && !up_match && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_leaf_switch.sv
// Directed bench for leaf_switch with a queue-based reference model checked every cycle.
module tb_leaf_switch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] loc_in_data = '0;
    logic [3:0]  loc_in_valid = '0;
    logic [3:0]  loc_in_ready;
    logic [63:0] loc_out_data;
    logic [3:0]  loc_out_valid;
    logic [15:0] up_in_data = '0;
    logic        up_in_valid = 1'b0;
    logic        up_in_ready;
    logic [15:0] up_out_data;
    logic        up_out_valid;
    logic        up_out_ready = 1'b1;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    leaf_switch dut (
        .clk           (clk),
        .reset         (reset),
        .loc_in_data   (loc_in_data),
        .loc_in_valid  (loc_in_valid),
        .loc_in_ready  (loc_in_ready),
        .loc_out_data  (loc_out_data),
        .loc_out_valid (loc_out_valid),
        .up_in_data    (up_in_data),
        .up_in_valid   (up_in_valid),
        .up_in_ready   (up_in_ready),
        .up_out_data   (up_out_data),
        .up_out_valid  (up_out_valid),
        .up_out_ready  (up_out_ready),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per input, a last-winner per output.
    logic [15:0] mq [5][$];
    int          m_last [5];
    logic [3:0]  m_loc_vld;
    logic [63:0] m_loc_dat;
    logic        m_up_vld;
    logic [15:0] m_up_dat;
    int          m_drop;

    function automatic int route(input logic [15:0] f);
        return (f[15:12] == 4'd8) ? int'(f[11:10]) : 4;
    endfunction

    task automatic model_step();
        bit ok;
        int sz [5];
        int win [5];
        int i;
        ok = !m_up_vld || up_out_ready;
        for (int p = 0; p < 5; p++) sz[p] = mq[p].size();
        for (int o = 0; o < 5; o++) begin
            win[o] = -1;
            for (int k = 1; k <= 5; k++) begin
                i = (m_last[o] + k) % 5;
                if (win[o] < 0 && sz[i] > 0 && route(mq[i][0]) == o && (o < 4 || ok)) win[o] = i;
            end
        end
        for (int o = 0; o < 4; o++) begin
            m_loc_vld[o] = (win[o] >= 0);
            if (win[o] >= 0) m_loc_dat[o*16 +: 16] = mq[win[o]][0];
        end
        if (ok) begin
            m_up_vld = (win[4] >= 0);
            if (win[4] >= 0) m_up_dat = mq[win[4]][0];
        end
        for (int o = 0; o < 5; o++) begin
            if (win[o] >= 0) begin
                m_last[o] = win[o];
                void'(mq[win[o]].pop_front());
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (loc_in_valid[p] && sz[p] < 4) mq[p].push_back(loc_in_data[p*16 +: 16]);
        end
        if (up_in_valid && sz[4] < 4) begin
            if (up_in_data[15:12] == 4'd8) mq[4].push_back(up_in_data);
            else if (m_drop < 255) m_drop++;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 5; p++) begin
                mq[p].delete();
                m_last[p] = 4;
            end
            m_loc_vld = '0;
            m_loc_dat = '0;
            m_up_vld  = 1'b0;
            m_up_dat  = '0;
            m_drop    = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic [3:0] mr;
            for (int p = 0; p < 4; p++) mr[p] = (mq[p].size() < 4);
            chk("m_loc_out_valid", loc_out_valid, m_loc_vld);
            chk("m_loc_out_data", loc_out_data, m_loc_dat);
            chk("m_up_out_valid", up_out_valid, m_up_vld);
            chk("m_up_out_data", up_out_data, m_up_dat);
            chk("m_drop_count", drop_count, 64'(m_drop));
            chk("m_loc_in_ready", loc_in_ready, mr);
            chk("m_up_in_ready", up_in_ready, mq[4].size() < 4);
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_loc_valid", loc_out_valid, 4'h0);
        chk("rst_up_valid", up_out_valid, 1'b0);
        chk("rst_loc_data", loc_out_data, 64'h0);
        chk("rst_up_data", up_out_data, 16'h0);
        chk("rst_drop", drop_count, 8'h0);
        #1 reset = 1'b0;
        #1 chk("ready_after_release", {up_in_ready, loc_in_ready}, 5'h1F);

        // Leaves 0, 2, 3 contend for leaf 1.
        @(posedge clk); #1;
        loc_in_valid = 4'b1101;
        loc_in_data  = 64'h8433_8422_0000_8411;
        @(posedge clk); #1;
        loc_in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        chk("cont_v0", loc_out_valid, 4'b0010);
        chk("cont_d0", loc_out_data[31:16], 16'h8411);
        @(negedge clk);
        chk("cont_v1", loc_out_valid, 4'b0010);
        chk("cont_d1", loc_out_data[31:16], 16'h8422);
        @(negedge clk);
        chk("cont_v2", loc_out_valid, 4'b0010);
        chk("cont_d2", loc_out_data[31:16], 16'h8433);
        @(negedge clk);
        chk("cont_end", loc_out_valid, 4'b0000);

        // Basic local route leaf0 -> leaf1.
        @(posedge clk); #1;
        loc_in_valid = 4'b0001;
        loc_in_data  = 64'h0000_0000_0000_8555;
        @(posedge clk); #1;
        loc_in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        chk("local_vld", loc_out_valid, 4'b0010);
        chk("local_dat", loc_out_data[31:16], 16'h8555);
        @(negedge clk);
        chk("local_one_cycle", loc_out_valid, 4'b0000);
        chk("local_hold", loc_out_data[31:16], 16'h8555);

        // Uplink ingress to leaf 3.
        @(posedge clk); #1;
        up_in_valid = 1'b1;
        up_in_data  = 16'h8C0F;
        @(posedge clk); #1;
        up_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ingress_vld", loc_out_valid, 4'b1000);
        chk("ingress_dat", loc_out_data[63:48], 16'h8C0F);

        // Uplink back-pressure with leaf 2 streaming.
        @(posedge clk); #1;
        up_out_ready = 1'b0;
        loc_in_valid = 4'b0100;
        loc_in_data[47:32] = 16'h4120;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!loc_in_ready[2]) break;
            @(posedge clk); #1;
            n++;
            loc_in_data[47:32] = 16'h4120 + 16'(n);
        end
        loc_in_valid = '0;
        chk("bp_accepted", 64'(n), 64'd5);
        chk("bp_up_vld", up_out_valid, 1'b1);
        chk("bp_up_dat", up_out_data, 16'h4120);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_vld", up_out_valid, 1'b1);
            chk("bp_hold_dat", up_out_data, 16'h4120);
            chk("bp_ready_low", loc_in_ready[2], 1'b0);
        end
        @(posedge clk); #1;
        up_out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("bp_drain_vld", up_out_valid, 1'b1);
            chk("bp_drain_dat", up_out_data, 16'h4120 + 16'(j));
        end
        @(negedge clk);
        chk("bp_drain_end", up_out_valid, 1'b0);

        // Misrouted uplink flits are dropped and counted.
        @(posedge clk); #1;
        up_in_valid = 1'b1;
        up_in_data  = 16'h4000;
        @(posedge clk); #1;
        up_in_valid = 1'b0;
        @(negedge clk);
        chk("drop_one", drop_count, 8'd1);
        @(negedge clk);
        chk("drop_no_loc", loc_out_valid, 4'h0);
        chk("drop_no_up", up_out_valid, 1'b0);
        @(posedge clk); #1;
        up_in_valid = 1'b1;
        repeat (259) @(posedge clk);
        #1 up_in_valid = 1'b0;
        @(negedge clk);
        chk("drop_saturate", drop_count, 8'd255);

        // Reset with traffic buffered and the uplink stage stalled.
        @(posedge clk); #1;
        up_out_ready = 1'b0;
        loc_in_valid = 4'hF;
        loc_in_data  = 64'h8004_4003_8002_8001;
        @(posedge clk); #1;
        loc_in_data  = 64'h8008_4007_8006_8005;
        @(posedge clk); #1;
        loc_in_valid = '0;
        @(posedge clk); #1;
        chk("pre_rst_up_vld", up_out_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_loc_vld", loc_out_valid, 4'h0);
        chk("mid_rst_up_vld", up_out_valid, 1'b0);
        chk("mid_rst_drop", drop_count, 8'h0);
        chk("mid_rst_up_dat", up_out_data, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        up_out_ready = 1'b1;
        #1 chk("ready_after_rerelease", {up_in_ready, loc_in_ready}, 5'h1F);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((|loc_out_valid) || up_out_valid) seen++;
        end
        chk("no_stale_after_reset", 64'(seen), 64'd0);

        // Mixed directed traffic under intermittent uplink back-pressure.
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            loc_in_valid = 4'(c * 7 + 5);
            for (int p = 0; p < 4; p++) begin
                loc_in_data[p*16 +: 16] = {(((c + p) % 3) == 0) ? 4'h3 : 4'h8, 2'((c + 2 * p) % 4), 10'(c * 8 + p)};
            end
            up_in_valid  = ((c % 2) == 0);
            up_in_data   = {((c % 4) == 0) ? 4'h5 : 4'h8, 2'(c % 4), 10'(c)};
            up_out_ready = ((c % 3) != 1);
        end
        @(posedge clk); #1;
        loc_in_valid = '0;
        up_in_valid  = 1'b0;
        up_out_ready = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("mixed_drained_up", up_out_valid, 1'b0);
        chk("mixed_drained_loc", loc_out_valid, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/leaf_switch.md
LEAF_SWITCH -- requirements
Module: leaf_switch

Interface
REQ-001 SHALL have parameter GROUP_ID, default 8, meaning the 4-bit group number this switch owns.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the flit width; header = bits [15:10], group = [15:12], leaf = [11:10].
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the per-input buffer depth; it SHALL be a power of 2.
REQ-004 SHALL have port clk, input, 1 bit: the clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port loc_in_data, input, 4*DATA_W bits: flits from NI leaf i, in slice [i*16 +: 16].
REQ-007 SHALL have port loc_in_valid, input, 4 bits: per-leaf flit valid.
REQ-008 SHALL have port loc_in_ready, output, 4 bits: per-leaf "switch can accept".
REQ-009 SHALL have port loc_out_data, output, 4*DATA_W bits: flits delivered to NI leaf i.
REQ-010 SHALL have port loc_out_valid, output, 4 bits: per-leaf one-cycle delivery strobe; there is no back-pressure from the NI.
REQ-011 SHALL have ports up_in_data (input, DATA_W), up_in_valid (input, 1) and up_in_ready (output, 1): the flit stream from the group router.
REQ-012 SHALL have ports up_out_data (output, DATA_W), up_out_valid (output, 1) and up_out_ready (input, 1): the flit stream to the group router.
REQ-013 SHALL have port drop_count, output, 8 bits: a saturating count of misrouted uplink flits.

Function
REQ-014 Input ports are numbered 0-3 for leaves and 4 for the uplink; each input SHALL have its own FIFO_DEPTH FIFO.
REQ-015 Input ready SHALL be !full, taken from the registered count; a flit SHALL be written when valid && ready, and a read and a write in the same cycle SHALL leave the count unchanged.
REQ-016 Routing of a FIFO head SHALL be: if group == GROUP_ID, go to the local output indexed by leaf; otherwise go to the uplink output. Local-to-same-leaf loopback is permitted.
REQ-017 An uplink-input flit whose group != GROUP_ID SHALL be discarded at the FIFO write and drop_count SHALL increment, saturating at 255; it SHALL still be accepted (ready honoured).
REQ-018 Each of the 5 outputs SHALL have a round-robin arbiter over the inputs whose head targets it; the search SHALL start at last_grant+1 and wrap 4 to 0. The pointer SHALL update only on a grant.
REQ-019 Each input head targets exactly one output, so an input SHALL pop at most one flit per cycle.
REQ-020 Local outputs SHALL be registered: on a grant, loc_out_data <= flit and loc_out_valid <= 1 for one cycle; otherwise valid <= 0 and data SHALL hold its last value.
REQ-021 The uplink output SHALL be a registered skid-free stage. It may load only when !up_out_valid || up_out_ready. Data and valid SHALL be held stable while up_out_valid && !up_out_ready.
REQ-022 Latency SHALL be: a flit accepted at edge k into an empty FIFO with an uncontended output appears valid after edge k+1.
REQ-023 Uncontended throughput SHALL be 1 flit per cycle per output.
REQ-024 Flits from the same input to the same output SHALL be delivered in order.

Reset
REQ-025 On reset, all FIFOs SHALL be emptied (pointers and counts = 0); loc_out_valid, up_out_valid, loc_out_data, up_out_data and drop_count SHALL be 0; all arbiter pointers SHALL be set so that input 0 has the highest priority.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered and in-flight flits, with no partial delivery after release.
REQ-027 loc_in_ready and up_in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-028 Basic local route: GROUP_ID=8; leaf0 sends 16'h8555 (header 100001) at edge k -> loc_out_valid[1]=1 with data 16'h8555 after edge k+1, for one cycle.
REQ-029 Local contention: leaves 0, 2 and 3 each send one flit to leaf1 in the same cycle -> leaf1 receives the leaf0, leaf2 and leaf3 flits on three consecutive cycles, in that order.
REQ-030 Uplink back-pressure: up_out_ready=0; leaf2 streams 16'h4123 (group 4) -> up_out_valid=1 with data stable; loc_in_ready[2] falls after 5 flits (4 in the FIFO + 1 in the output register); with up_out_ready=1, all 5 exit in order and one per cycle.
REQ-031 Misroute drop: up_in sends 16'h4000 -> no output valid; drop_count=1; 260 such flits -> drop_count=255.
REQ-032 Uplink ingress: up_in sends 16'h8C0F (group 8, leaf 3) -> loc_out_valid[3]=1 with data 16'h8C0F two edges later.
REQ-033 Reset mid-operation: with FIFOs partly full and up_out_valid=1, assert reset -> all valids and drop_count read 0 immediately; after release, no stale flit ever appears on any output.
